mod_n_cascade_counter: RTL and testbench
========================================

Name: mod_n_cascade_counter

Overview:
- Synchronous, parametrised successor to the team's mod-10 ripple counter.
- Holds DIGITS cascaded digits. Each digit counts modulo MODULUS.
- Adds up/down counting, parallel load, count enable, selectable wrap/saturate mode and a terminal-count flag.
- Used as the time-base/event counter in lab datapaths (e.g. 2-digit BCD display counters). All flops are on one clock; there are no derived clocks.

Parameters:
- MODULUS, 10, count states per digit (2..256).
- DIGITS, 2, number of cascaded digits (1..8).
- SATURATE, 0, behaviour at the extreme value: 0 = wrap around, 1 = hold at the extreme.
- DIGIT_W, $clog2(MODULUS), bits per digit (derived; do not override).

Ports:
- clk  input  1  Single clock. Rising-edge only.
- rst  input  1  Synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  Count enable. Advances the count by one step per cycle while high.
- up  input  1  Direction: 1 = increment, 0 = decrement.
- load  input  1  Synchronous parallel load.
- load_val  input  DIGITS*DIGIT_W  Load value. Digit 0 is in the LSBs.
- count  output  DIGITS*DIGIT_W  Current count, registered, per-digit packed.
- tc  output  1  Terminal count, combinational from count and up. High when all digits = MODULUS-1 (up=1) or all digits = 0 (up=0).
- wrap  output  1  Registered one-cycle pulse. High the cycle after the count wraps.
- sat  output  1  Registered level. High while the count is held at an extreme by SATURATE=1.
- load_err  output  1  Registered one-cycle pulse. High the cycle after a load that contained an out-of-range digit.

Behaviour:
- Reset: count=0, wrap=0, sat=0, load_err=0. Takes effect on the clk edge where rst=1. Reset mid-count discards the count with no wrap pulse.
- Per-edge priority: rst > load > en. When neither load nor en is high, count holds, and wrap and load_err go to 0.
- Load:
  - count <= load_val on the edge, with one correction: any digit >= MODULUS is replaced by 0.
  - load_err=1 on the following cycle if any digit was replaced; otherwise 0.
  - Load clears sat and suppresses wrap.
  - A load together with en loads; no count step occurs that cycle.
- Up count (en=1, up=1):
  - Digit 0 increments.
  - Digit k changes only when every lower digit = MODULUS-1. A digit at MODULUS-1 that changes goes to 0.
  - All digits change on the same edge (synchronous cascade, no ripple).
- Down count (en=1, up=0): mirror of up. Digit k changes only when every lower digit = 0. A digit at 0 goes to MODULUS-1.
- Extremes, tc=1 and en=1:
  - SATURATE=0: count wraps to the opposite extreme (all 0 going up, all MODULUS-1 going down). wrap=1 for exactly the next cycle.
  - SATURATE=1: count holds and sat=1. sat stays high until a step in the opposite direction, a load or rst; it clears on that edge's result. wrap never asserts.
- Direction change: up is sampled every edge, and a flip takes effect on that edge. tc follows up combinationally.
- Latency:
  - count: updates one edge after en/load.
  - tc: zero-cycle function of count and up.
  - wrap, sat, load_err: registered, valid the cycle after the causing edge.
- Width: all digit arithmetic is DIGIT_W bits. A value >= MODULUS is unreachable except through load, which corrects it. With MODULUS a power of two, the wrap compare still uses MODULUS-1 explicitly.

Decomposition:
- Shared package (counter_pkg):
  - Function for the DIGIT_W calculation.
  - Localparams for the mode encoding (MODE_WRAP=0, MODE_SAT=1).
- Sub-module mod_n_digit: one digit register.
  - Inputs: clk, rst, load, load_digit, step, up.
  - Outputs: value, at_max, at_min, load_bad.
- Top level:
  - Instantiates DIGITS copies with a generate loop.
  - Builds the step chain with a prefix-AND of at_max/at_min, gated by en, tc and SATURATE.
  - Registers wrap, sat and load_err.

Test Plan (MODULUS=10, DIGITS=2 unless stated):
1. rst=1 with en=1 for 1 edge after a random count -> count=0x00, wrap=0, sat=0. en up for 23 edges -> count digits {2,3}.
2. Load {9,8}, then en up for 2 edges -> count {9,9} with tc=1, then {0,0}. wrap=1 for exactly one cycle, then 0.
3. SATURATE=1: load {0,1}, en down for 3 edges -> count {0,0}, {0,0}, {0,0}. sat=1 from the cycle after the second edge. One en up edge -> count {0,1}, sat=0.
4. Load {12,3} (digit 1 invalid) with en=1 -> count {0,3}, load_err=1 for one cycle, no count step that edge.
5. Count {1,9} up, flip up=0 on the same edge as en -> count {1,8}. Then en up -> {1,9}, then {2,0} (carry across digits on a single edge).
6. MODULUS=16, DIGITS=1, en up from 15 -> count 0, wrap pulse. rst asserted on the wrap edge -> count 0, wrap=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N cascade counter: digit width helper and
// wrap/saturate mode encoding.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold 0..modulus-1; a modulus of 2 still needs one bit.
    function automatic int calc_digit_w(input int modulus);
        if (modulus <= 2) begin
            return 1;
        end else begin
            return $clog2(modulus);
        end
    endfunction

endpackage

// File: rtl/mod_n_digit.sv
// One digit of the cascade: a modulo-MODULUS register with load correction,
// single-step up/down and extreme-value flags for the carry/borrow chain.
module mod_n_digit
    import counter_pkg::*;
#(
    parameter int MODULUS = 10,
    parameter int DIGIT_W = calc_digit_w(MODULUS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [DIGIT_W-1:0] load_digit,
    input  logic               step,
    input  logic               up,
    output logic [DIGIT_W-1:0] value,
    output logic               at_max,
    output logic               at_min,
    output logic               load_bad
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W:0]   MOD_V = (DIGIT_W + 1)'(MODULUS);

    logic [DIGIT_W-1:0] value_q;
    logic [DIGIT_W-1:0] value_d;

    assign at_max   = (value_q == MAX_V);
    assign at_min   = (value_q == {DIGIT_W{1'b0}});
    assign load_bad = ({1'b0, load_digit} >= MOD_V);
    assign value    = value_q;

    // Next digit value: load (with out-of-range digits forced to zero) beats a step.
    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_bad ? {DIGIT_W{1'b0}} : load_digit;
        end else if (step) begin
            if (up) begin
                value_d = at_max ? {DIGIT_W{1'b0}} : value_q + DIGIT_W'(1);
            end else begin
                value_d = at_min ? MAX_V : value_q - DIGIT_W'(1);
            end
        end else begin
            value_d = value_q;
        end
    end

    // Digit register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= {DIGIT_W{1'b0}};
        end else begin
            value_q <= value_d;
        end
    end

endmodule

// File: rtl/mod_n_cascade_counter.sv
// Synchronous DIGITS-digit modulo-MODULUS counter with up/down, parallel load,
// wrap or saturate at the extremes, and registered status pulses.
module mod_n_cascade_counter
    import counter_pkg::*;
#(
    parameter int MODULUS  = 10,
    parameter int DIGITS   = 2,
    parameter int SATURATE = MODE_WRAP,
    parameter int DIGIT_W  = calc_digit_w(MODULUS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      up,
    input  logic                      load,
    input  logic [DIGITS*DIGIT_W-1:0] load_val,
    output logic [DIGITS*DIGIT_W-1:0] count,
    output logic                      tc,
    output logic                      wrap,
    output logic                      sat,
    output logic                      load_err
);

    localparam logic SAT_MODE = (SATURATE == MODE_SAT);

    logic [DIGITS-1:0] at_max_s;
    logic [DIGITS-1:0] at_min_s;
    logic [DIGITS-1:0] bad_s;
    logic [DIGITS-1:0] step_s;
    logic [DIGITS:0]   chain_up_s;
    logic [DIGITS:0]   chain_dn_s;
    logic              hold_s;
    logic              step_en_s;

    logic wrap_q, wrap_d;
    logic sat_q, sat_d;
    logic load_err_q, load_err_d;

    assign chain_up_s[0] = 1'b1;
    assign chain_dn_s[0] = 1'b1;

    // Prefix-AND chains: digit g moves only when every lower digit is at its extreme.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign chain_up_s[g+1] = chain_up_s[g] & at_max_s[g];
        assign chain_dn_s[g+1] = chain_dn_s[g] & at_min_s[g];
        assign step_s[g]       = step_en_s & (up ? chain_up_s[g] : chain_dn_s[g]);

        mod_n_digit #(
            .MODULUS (MODULUS),
            .DIGIT_W (DIGIT_W)
        ) u_digit (
            .clk        (clk),
            .rst        (rst),
            .load       (load),
            .load_digit (load_val[g*DIGIT_W +: DIGIT_W]),
            .step       (step_s[g]),
            .up         (up),
            .value      (count[g*DIGIT_W +: DIGIT_W]),
            .at_max     (at_max_s[g]),
            .at_min     (at_min_s[g]),
            .load_bad   (bad_s[g])
        );
    end

    assign tc        = up ? chain_up_s[DIGITS] : chain_dn_s[DIGITS];
    assign hold_s    = SAT_MODE & tc;
    assign step_en_s = en & ~load & ~hold_s;

    // Status next-state: sat holds while idle, is re-evaluated on every enabled step.
    always_comb begin
        wrap_d     = en & ~load & tc & ~SAT_MODE;
        load_err_d = load & (|bad_s);
        sat_d      = sat_q;
        if (load) begin
            sat_d = 1'b0;
        end else if (en) begin
            sat_d = hold_s;
        end else begin
            sat_d = sat_q;
        end
    end

    // Status registers; reset discards any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_mod_n_cascade_counter.sv
// Self-checking bench: three counter configurations driven in lockstep and
// compared every cycle against an integer-valued reference model.
module tb_mod_n_cascade_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [7:0] lv8 = 8'h00;
    logic [3:0] lv4 = 4'h0;

    logic [7:0] c0, c1;
    logic [3:0] c2;
    logic       tc0, tc1, tc2, wr0, wr1, wr2, sa0, sa1, sa2, le0, le1, le2;

    int checks = 0;
    int errors = 0;

    // model state, one slot per instance
    int mval[3];
    bit mwrap[3];
    bit msat[3];
    bit mlerr[3];

    always #5 clk = ~clk;

    mod_n_cascade_counter #(.MODULUS(10), .DIGITS(2), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv8),
        .count(c0), .tc(tc0), .wrap(wr0), .sat(sa0), .load_err(le0));

    mod_n_cascade_counter #(.MODULUS(10), .DIGITS(2), .SATURATE(1)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv8),
        .count(c1), .tc(tc1), .wrap(wr1), .sat(sa1), .load_err(le1));

    mod_n_cascade_counter #(.MODULUS(16), .DIGITS(1), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv4),
        .count(c2), .tc(tc2), .wrap(wr2), .sat(sa2), .load_err(le2));

    function automatic int mod_of(input int i);
        return (i == 2) ? 16 : 10;
    endfunction

    function automatic int ndig_of(input int i);
        return (i == 2) ? 1 : 2;
    endfunction

    function automatic bit satm_of(input int i);
        return (i == 1);
    endfunction

    function automatic int dw_of(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic int total_of(input int i);
        int r = 1;
        for (int d = 0; d < ndig_of(i); d++) r = r * mod_of(i);
        return r;
    endfunction

    function automatic int digit_of_raw(input int raw, input int i, input int d);
        int dw = dw_of(mod_of(i));
        return (raw >> (d * dw)) & ((1 << dw) - 1);
    endfunction

    // Value of a load word after replacing out-of-range digits with zero.
    function automatic int load_fix(input int raw, input int i);
        int v = 0;
        int dg;
        for (int d = ndig_of(i) - 1; d >= 0; d--) begin
            dg = digit_of_raw(raw, i, d);
            if (dg >= mod_of(i)) dg = 0;
            v = v * mod_of(i) + dg;
        end
        return v;
    endfunction

    function automatic bit load_bad(input int raw, input int i);
        bit b = 1'b0;
        for (int d = 0; d < ndig_of(i); d++)
            if (digit_of_raw(raw, i, d) >= mod_of(i)) b = 1'b1;
        return b;
    endfunction

    // Pack an integer count into per-digit fields, digit 0 in the LSBs.
    function automatic logic [31:0] to_packed(input int v, input int i);
        logic [31:0] p = 32'h0;
        int rest = v;
        int dw = dw_of(mod_of(i));
        for (int d = 0; d < ndig_of(i); d++) begin
            p = p | (32'(rest % mod_of(i)) << (d * dw));
            rest = rest / mod_of(i);
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int i);
        int top = total_of(i) - 1;
        int raw = (i == 2) ? int'(lv4) : int'(lv8);
        if (rst) begin
            mval[i] = 0; mwrap[i] = 1'b0; msat[i] = 1'b0; mlerr[i] = 1'b0;
        end else if (load) begin
            mval[i] = load_fix(raw, i); mlerr[i] = load_bad(raw, i);
            mwrap[i] = 1'b0; msat[i] = 1'b0;
        end else if (en) begin
            mlerr[i] = 1'b0;
            mwrap[i] = 1'b0;
            msat[i]  = 1'b0;
            if ((up && mval[i] == top) || (!up && mval[i] == 0)) begin
                if (satm_of(i)) msat[i] = 1'b1;
                else begin
                    mval[i]  = up ? 0 : top;
                    mwrap[i] = 1'b1;
                end
            end else begin
                mval[i] = up ? mval[i] + 1 : mval[i] - 1;
            end
        end else begin
            mwrap[i] = 1'b0; mlerr[i] = 1'b0;
        end
    endtask

    task automatic compare(input int i);
        logic [31:0] act_c;
        logic        act_tc, act_wr, act_sa, act_le;
        bit          exp_tc;
        case (i)
            0: begin act_c = 32'(c0); act_tc = tc0; act_wr = wr0; act_sa = sa0; act_le = le0; end
            1: begin act_c = 32'(c1); act_tc = tc1; act_wr = wr1; act_sa = sa1; act_le = le1; end
            default: begin act_c = 32'(c2); act_tc = tc2; act_wr = wr2; act_sa = sa2; act_le = le2; end
        endcase
        exp_tc = up ? (mval[i] == total_of(i) - 1) : (mval[i] == 0);
        chk($sformatf("u%0d count", i), act_c, to_packed(mval[i], i));
        chk($sformatf("u%0d tc", i), 32'(act_tc), 32'(exp_tc));
        chk($sformatf("u%0d wrap", i), 32'(act_wr), 32'(mwrap[i]));
        chk($sformatf("u%0d sat", i), 32'(act_sa), 32'(msat[i]));
        chk($sformatf("u%0d load_err", i), 32'(act_le), 32'(mlerr[i]));
    endtask

    // Reference model advances on each edge; outputs compared just after it.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) model_step(i);
        #1;
        for (int i = 0; i < 3; i++) compare(i);
    end

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [7:0] v8, input logic [3:0] v4);
        load = 1'b1; en = 1'b0; lv8 = v8; lv4 = v4;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        cyc(1);
        // 1: count a while, reset with en high, then 23 up steps
        rst = 1'b0; en = 1'b1; up = 1'b1;
        cyc(7);
        rst = 1'b1;
        cyc(1);
        chk("t1 reset count", 32'(c0), 32'h00);
        chk("t1 reset wrap", 32'(wr0), 32'h0);
        rst = 1'b0;
        cyc(23);
        chk("t1 count 23", 32'(c0), 32'h23);
        // 2: wrap from 99
        do_load(8'h98, 4'h8);
        en = 1'b1; up = 1'b1;
        cyc(1);
        chk("t2 count 99", 32'(c0), 32'h99);
        chk("t2 tc", 32'(tc0), 32'h1);
        cyc(1);
        chk("t2 count 00", 32'(c0), 32'h00);
        chk("t2 wrap pulse", 32'(wr0), 32'h1);
        en = 1'b0;
        cyc(1);
        chk("t2 wrap cleared", 32'(wr0), 32'h0);
        // 3: saturate at zero going down
        do_load(8'h01, 4'h1);
        en = 1'b1; up = 1'b0;
        cyc(1);
        chk("t3 count e1", 32'(c1), 32'h00);
        chk("t3 sat e1", 32'(sa1), 32'h0);
        cyc(1);
        chk("t3 sat e2", 32'(sa1), 32'h1);
        cyc(1);
        chk("t3 count e3", 32'(c1), 32'h00);
        chk("t3 wrap never", 32'(wr1), 32'h0);
        up = 1'b1;
        cyc(1);
        chk("t3 count up", 32'(c1), 32'h01);
        chk("t3 sat cleared", 32'(sa1), 32'h0);
        // 4: load with invalid digit 1 and en high
        load = 1'b1; en = 1'b1; up = 1'b1; lv8 = 8'hC3; lv4 = 4'h3;
        cyc(1);
        chk("t4 corrected", 32'(c0), 32'h03);
        chk("t4 load_err", 32'(le0), 32'h1);
        load = 1'b0; en = 1'b0;
        cyc(1);
        chk("t4 load_err clr", 32'(le0), 32'h0);
        // 5: direction flip and digit carry
        do_load(8'h19, 4'h9);
        en = 1'b1; up = 1'b0;
        cyc(1);
        chk("t5 down", 32'(c0), 32'h18);
        up = 1'b1;
        cyc(2);
        chk("t5 carry", 32'(c0), 32'h20);
        // 6: MODULUS=16 single digit wrap, then reset on a wrap edge
        do_load(8'h00, 4'hF);
        en = 1'b1; up = 1'b1;
        cyc(1);
        chk("t6 count 0", 32'(c2), 32'h0);
        chk("t6 wrap", 32'(wr2), 32'h1);
        do_load(8'h00, 4'hF);
        rst = 1'b1; en = 1'b1; up = 1'b1;
        cyc(1);
        chk("t6 rst count", 32'(c2), 32'h0);
        chk("t6 rst wrap", 32'(wr2), 32'h0);
        rst = 1'b0;
        // mixed directed sweep, checked by the per-cycle model
        for (int k = 0; k < 60; k++) begin
            en   = (k % 3) != 0;
            up   = ((k / 5) % 2) == 0;
            load = (k % 13) == 7;
            lv8  = 8'((k * 37) % 256);
            lv4  = lv8[3:0];
            rst  = (k == 41);
            cyc(1);
        end
        rst = 1'b0; en = 1'b0; load = 1'b0;
        cyc(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
